mux8_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the 8-input select mux in the forwarding/redirect datapath.
- Shares the mux between 8 requesters.
- Drives the mux select and its active-high disable, so a disabled mux outputs 0.
- Qualifies the selected data toward a single consumer with a valid/ready handshake, plus a stall timeout.

---
 rtl/mux8_rr_arbiter.sv | 110 +++++++++++
 tb/tb_mux8_rr_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin owner of the 8-input forwarding mux with valid/ready qualification and stall timeout.
// Define ARB_LOCK_EN to add the lock port for burst re-grants.
module mux8_rr_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
`ifdef ARB_LOCK_EN
    input  logic [7:0] lock,
`endif
    input  logic       out_ready,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       mux_disable,
    output logic       out_valid,
    output logic       done,
    output logic       timeout
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t     state_q, state_d;
    logic [7:0] gnt_q, gnt_d, cnt_q, cnt_d;
    logic [2:0] sel_q, sel_d, ptr_q, ptr_d, nptr;
    logic       done_q, done_d, timeout_q, timeout_d, lock_hit, expire;
    logic [3:0] win_i, win_h;
    // {found, index} of the first set bit scanning p, p+1, ... with wrap
    function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] idx;
        pick = '0;
        for (int i = 7; i >= 0; i--) begin
            idx = p + 3'(i);
            if (r[idx]) pick = {1'b1, idx};
        end
    endfunction
`ifdef ARB_LOCK_EN
    assign lock_hit = lock[sel_q] & req[sel_q];
`else
    assign lock_hit = 1'b0;
`endif
    assign nptr   = sel_q + 3'd1;
    assign win_i  = pick(req, ptr_q);
    assign win_h  = pick(req, nptr);
    assign expire = (TIMEOUT != 0) && (cnt_q == 8'(TIMEOUT - 1));
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        if (state_q == IDLE) begin
            if (win_i[3]) begin
                state_d = BUSY;
                sel_d   = win_i[2:0];
                gnt_d   = 8'b1 << win_i[2:0];
                cnt_d   = '0;
            end
        end else if (out_ready) begin
            done_d = 1'b1;
            cnt_d  = '0;
            if (!lock_hit) begin
                // the finished requester is scanned last from nptr, so it only wins when alone
                ptr_d = nptr;
                if (win_h[3]) begin
                    sel_d = win_h[2:0];
                    gnt_d = 8'b1 << win_h[2:0];
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
        end else if (!req[sel_q]) begin
            state_d = IDLE;
            gnt_d   = '0;
        end else if (expire) begin
            timeout_d = 1'b1;
            ptr_d     = nptr;
            state_d   = IDLE;
            gnt_d     = '0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            sel_q     <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end
    assign gnt         = gnt_q;
    assign sel         = sel_q;
    assign out_valid   = state_q == BUSY;
    assign mux_disable = state_q != BUSY;
    assign done        = done_q;
    assign timeout     = timeout_q;
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter: directed and randomized checks of mux8_rr_arbiter against a behavioural round-robin model.
// Lock behaviour is exercised when ARB_LOCK_EN is defined.
module tb_mux8_rr_arbiter;
    localparam int T = 16;
    logic       clk = 1'b0, rst_n = 1'b0, out_ready = 1'b0;
    logic [7:0] req = '0, lock_v = '0;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       mux_disable, out_valid, done, timeout;
    int vectors = 0, miscompares = 0;
    bit m_busy, m_done, m_to;
    int m_sel, m_ptr, m_age;
    mux8_rr_arbiter #(.TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
`ifdef ARB_LOCK_EN
        .lock(lock_v),
`endif
        .out_ready(out_ready), .gnt(gnt), .sel(sel), .mux_disable(mux_disable),
        .out_valid(out_valid), .done(done), .timeout(timeout)
    );
    always #5 clk = ~clk;
    function automatic int rr(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) if (r[(p + k) % 8]) return (p + k) % 8;
        return -1;
    endfunction
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic chk_all;
        chk("gnt", gnt, m_busy ? 8'(1 << m_sel) : 8'h00);
        chk("sel", {5'b0, sel}, 8'(m_sel));
        chk("out_valid", {7'b0, out_valid}, {7'b0, m_busy});
        chk("mux_disable", {7'b0, mux_disable}, {7'b0, !m_busy});
        chk("done", {7'b0, done}, {7'b0, m_done});
        chk("timeout", {7'b0, timeout}, {7'b0, m_to});
    endtask
    task automatic model_reset;
        m_busy = 0; m_done = 0; m_to = 0; m_sel = 0; m_ptr = 0; m_age = 0;
    endtask
    task automatic model_edge(input logic [7:0] r, input logic rd, input logic [7:0] lk);
        bit locked;
`ifdef ARB_LOCK_EN
        locked = lk[m_sel] && r[m_sel];
`else
        locked = lk[0] && 1'b0;
`endif
        m_done = 0; m_to = 0;
        if (!m_busy) begin
            if (r != 0) begin m_sel = rr(r, m_ptr); m_busy = 1; m_age = 0; end
        end else if (rd) begin
            m_done = 1; m_age = 0;
            if (!locked) begin
                m_ptr = (m_sel + 1) % 8;
                if (r != 0) m_sel = rr(r, m_ptr); else m_busy = 0;
            end
        end else if (!r[m_sel]) begin
            m_busy = 0;
        end else if (T != 0 && m_age + 1 == T) begin
            m_to = 1; m_ptr = (m_sel + 1) % 8; m_busy = 0;
        end else begin
            m_age++;
        end
    endtask
    task automatic cyc(input logic [7:0] r, input logic rd, input logic [7:0] lk);
        req = r; out_ready = rd; lock_v = lk;
        @(posedge clk);
        model_edge(r, rd, lk);
        @(negedge clk);
        chk_all();
    endtask
    task automatic do_reset;
        #2 rst_n = 1'b0;
        #1 model_reset();
        chk_all();
        @(negedge clk) rst_n = 1'b1;
    endtask
    int mode;
    logic [7:0] hr, r;
    logic rd;
    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk_all();
        rst_n = 1'b1;
        cyc(8'h04, 0, 0);
        do_reset();
        for (int i = 0; i < 10; i++) cyc(8'hFF, 1, 0);
        do_reset();
        cyc(8'h20, 0, 0);
        cyc(8'h00, 1, 0);
        cyc(8'h03, 0, 0);
        cyc(8'h03, 1, 0);
        cyc(8'h00, 1, 0);
        do_reset();
        cyc(8'h08, 0, 0);
        for (int i = 0; i < T + 2; i++) cyc(8'h18, 0, 0);
        do_reset();
        cyc(8'h04, 0, 0);
        cyc(8'h00, 0, 0);
        cyc(8'h04, 0, 0);
        cyc(8'h04, 1, 0);
`ifdef ARB_LOCK_EN
        do_reset();
        for (int i = 0; i < 5; i++) cyc(8'h06, 1, 8'h02);
        for (int i = 0; i < 3; i++) cyc(8'h06, 1, 8'h00);
`endif
        for (int s = 0; s < 160; s++) begin
            mode = $urandom_range(0, 3);
            hr = 8'($urandom);
            for (int c = 0; c < 25; c++) begin
                case (mode)
                    0: begin r = 8'($urandom); rd = 1'($urandom); end
                    1: begin r = hr; rd = 1'b0; end
                    2: begin r = hr | 8'(1 << $urandom_range(0, 7)); rd = $urandom_range(0, 3) == 0; end
                    default: begin r = 8'($urandom & $urandom); rd = 1'b1; end
                endcase
                cyc(r, rd, 8'($urandom));
            end
            if (s % 40 == 39) do_reset();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
